// File: rtl/range_alarm_pkg.sv
// range_alarm_pkg: shared radar types and defaults (zone encoding, distance width, clamp limit)
package range_alarm_pkg;

    typedef enum logic [1:0] {
        ZONE_IDLE = 2'd0,
        ZONE_FAR  = 2'd1,
        ZONE_MID  = 2'd2,
        ZONE_NEAR = 2'd3
    } zone_t;

    localparam int DIST_W_DEF = 11;
    localparam int MAX_CM_DEF = 400;

endpackage

// File: rtl/range_alarm_ms_tick_gen.sv
// ms_tick_gen: free-running prescaler, tick pulses for one cycle at terminal count
//   clk, rst (async, active-high) -> tick (1 cycle every TICK_DIV cycles)
module ms_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/range_alarm.sv
// range_alarm: 4-sample moving average, hysteretic FAR/MID/NEAR zoning, buzzer pattern, stale-sensor flag
//   in : clk, rst (async, active-high), dist_valid, dist_cm
//   out: avg_cm, avg_valid, zone (0 IDLE,1 FAR,2 MID,3 NEAR), buzzer, stale
module range_alarm
    import range_alarm_pkg::*;
#(
    parameter int DIST_W      = DIST_W_DEF,
    parameter int MAX_CM      = MAX_CM_DEF,
    parameter int FAR_CM      = 150,
    parameter int NEAR_CM     = 50,
    parameter int HYST_CM     = 10,
    parameter int TICK_DIV    = 1000,
    parameter int TIMEOUT_MS  = 100,
    parameter int BEEP_ON_MS  = 100,
    parameter int BEEP_OFF_MS = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_cm,
    output logic [DIST_W-1:0] avg_cm,
    output logic              avg_valid,
    output logic [1:0]        zone,
    output logic              buzzer,
    output logic              stale
);
    localparam int SW  = DIST_W + 2;
    localparam int MW  = $clog2(TIMEOUT_MS + 1);
    localparam int PER = BEEP_ON_MS + BEEP_OFF_MS;
    localparam int BW  = $clog2(PER);

    logic              tick;
    logic              timeout;
    logic [DIST_W-1:0] s;
    logic [DIST_W-1:0] hist [4];
    logic [SW-1:0]     sum;
    logic [SW-1:0]     sum_nxt;
    logic [2:0]        fill;
    logic [MW-1:0]     ms;
    logic [BW-1:0]     beep;
    logic [BW-1:0]     beep_nxt;
    logic              lt_near;
    logic              lt_far;
    logic              ge_near_h;
    logic              ge_far_h;
    zone_t             zone_q;
    zone_t             zone_cls;
    zone_t             zone_nxt;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign zone = zone_q;

    always_comb begin
        s         = dist_cm > DIST_W'(MAX_CM) ? DIST_W'(MAX_CM) : dist_cm;
        // the oldest entry drops out as the new one enters
        sum_nxt   = sum + SW'(s) - SW'(hist[3]);
        // a sample in the same cycle pre-empts the timeout
        timeout   = tick && !dist_valid && ms == MW'(TIMEOUT_MS - 1);
        lt_near   = avg_cm < DIST_W'(NEAR_CM);
        lt_far    = avg_cm < DIST_W'(FAR_CM);
        ge_near_h = avg_cm >= DIST_W'(NEAR_CM + HYST_CM);
        ge_far_h  = avg_cm >= DIST_W'(FAR_CM + HYST_CM);
        // IDLE and FAR share the plain entry thresholds
        zone_cls  = zone_q == ZONE_MID  ? (lt_near ? ZONE_NEAR : ge_far_h ? ZONE_FAR : ZONE_MID) :
                    zone_q == ZONE_NEAR ? (ge_far_h ? ZONE_FAR : ge_near_h ? ZONE_MID : ZONE_NEAR) :
                    (lt_near ? ZONE_NEAR : lt_far ? ZONE_MID : ZONE_FAR);
        zone_nxt  = timeout ? ZONE_IDLE : avg_valid ? zone_cls : zone_q;
        // beep phase counts ms through one on+off period, restarting on MID entry
        beep_nxt  = (zone_nxt == ZONE_MID && zone_q != ZONE_MID) ? '0 :
                    (tick && zone_q == ZONE_MID) ? (beep == BW'(PER - 1) ? '0 : beep + 1'b1) :
                    beep;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '{default: '0};
            sum       <= '0;
            fill      <= '0;
            avg_cm    <= '0;
            avg_valid <= 1'b0;
            zone_q    <= ZONE_IDLE;
            beep      <= '0;
            buzzer    <= 1'b0;
            ms        <= '0;
            stale     <= 1'b0;
        end else begin
            if (dist_valid) begin
                hist <= '{s, hist[0], hist[1], hist[2]};
                sum  <= sum_nxt;
                fill <= fill == 3'd4 ? fill : fill + 3'd1;
            end else if (timeout) begin
                hist <= '{default: '0};
                sum  <= '0;
                fill <= '0;
            end
            avg_valid <= dist_valid && fill >= 3'd3;
            avg_cm    <= (dist_valid && fill >= 3'd3) ? DIST_W'(sum_nxt >> 2) : avg_cm;
            zone_q    <= zone_nxt;
            beep      <= beep_nxt;
            buzzer    <= zone_nxt == ZONE_NEAR || (zone_nxt == ZONE_MID && beep_nxt < BW'(BEEP_ON_MS));
            ms        <= dist_valid ? '0 : (tick && ms != MW'(TIMEOUT_MS)) ? ms + 1'b1 : ms;
            stale     <= dist_valid ? 1'b0 : timeout ? 1'b1 : stale;
        end
    end
endmodule

// File: tb/tb_range_alarm.sv
// tb_range_alarm: randomized and directed stimulus checked against a behavioural model
module tb_range_alarm;
    localparam int TD  = 10;
    localparam int TO  = 100;
    localparam int ON  = 100;
    localparam int PER = 500;

    logic        clk = 0;
    logic        rst = 0;
    logic        dist_valid = 0;
    logic [10:0] dist_cm = 0;
    logic [10:0] avg_cm;
    logic        avg_valid;
    logic [1:0]  zone;
    logic        buzzer;
    logic        stale;

    range_alarm #(
        .DIST_W(11), .MAX_CM(400), .FAR_CM(150), .NEAR_CM(50), .HYST_CM(10),
        .TICK_DIV(TD), .TIMEOUT_MS(TO), .BEEP_ON_MS(ON), .BEEP_OFF_MS(PER - ON)
    ) dut (
        .clk(clk), .rst(rst), .dist_valid(dist_valid), .dist_cm(dist_cm),
        .avg_cm(avg_cm), .avg_valid(avg_valid), .zone(zone), .buzzer(buzzer), .stale(stale)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int q[$];
    int m_avg, m_zone, m_ncyc, m_ms, m_mt;
    bit m_av, m_buz, m_stale;

    function automatic int classify(input int z, input int a);
        if (z == 2) return a < 50 ? 3 : a >= 160 ? 1 : 2;
        if (z == 3) return a >= 160 ? 1 : a >= 60 ? 2 : 3;
        return a < 50 ? 3 : a < 150 ? 2 : 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit tick, tmo;
        int nz, s;
        if (rst) begin
            q.delete();
            m_avg = 0; m_zone = 0; m_ncyc = 0; m_ms = 0; m_mt = 0;
            m_av = 0; m_buz = 0; m_stale = 0;
        end else begin
            tick = (m_ncyc % TD) == TD - 1;
            tmo  = tick && !dist_valid && m_ms == TO - 1;
            nz   = tmo ? 0 : m_av ? classify(m_zone, m_avg) : m_zone;
            if (nz == 2 && m_zone != 2) m_mt = 0;
            else if (nz == 2 && tick) m_mt++;
            m_buz  = nz == 3 || (nz == 2 && (m_mt % PER) < ON);
            m_zone = nz;
            m_av   = 0;
            if (dist_valid) begin
                s = dist_cm > 400 ? 400 : int'(dist_cm);
                q.push_front(s);
                if (q.size() > 4) void'(q.pop_back());
                if (q.size() == 4) begin
                    m_av  = 1;
                    m_avg = q.sum() / 4;
                end
                m_ms = 0;
                m_stale = 0;
            end else begin
                if (tick && m_ms < TO) m_ms++;
                if (tmo) begin
                    m_stale = 1;
                    q.delete();
                end
            end
            m_ncyc++;
        end
    end

    bit av_seen = 0;
    bit buz_hi = 0;
    bit buz_lo = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("avg_valid", avg_valid, m_av);
            if (m_av) check("avg_cm", avg_cm, m_avg);
            check("zone", zone, m_zone);
            check("buzzer", buzzer, m_buz);
            check("stale", stale, m_stale);
            if (avg_valid) av_seen = 1;
            if (zone == 2 && buzzer) buz_hi = 1;
            if (zone == 2 && !buzzer) buz_lo = 1;
        end
    end

    task automatic send(input int v, input int gap);
        @(negedge clk);
        dist_valid = 1;
        dist_cm = 11'(v);
        @(negedge clk);
        dist_valid = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send4(input int v);
        repeat (4) send(v, $urandom_range(3, 30));
    endtask

    initial begin
        #2 rst = 1;
        #1;
        check("rst_avg", avg_cm, 0);
        check("rst_av", avg_valid, 0);
        check("rst_zone", zone, 0);
        check("rst_buz", buzzer, 0);
        check("rst_stale", stale, 0);
        repeat (3) @(negedge clk);
        rst = 0;

        repeat (3) send(200, 5);
        check("warm_av", av_seen, 0);
        check("warm_zone", zone, 0);
        send(200, 5);
        check("warm_avg", avg_cm, 200);
        check("warm_far", zone, 1);

        send4(140);
        check("mid_avg", avg_cm, 140);
        check("mid_zone", zone, 2);
        send(170, 5);
        check("h1_avg", avg_cm, 147);
        check("h1_zone", zone, 2);
        send(170, 5);
        check("h2_avg", avg_cm, 155);
        check("h2_zone", zone, 2);
        send(170, 5);
        check("h3_avg", avg_cm, 162);
        check("h3_zone", zone, 1);
        send4(155);
        check("h4_zone", zone, 1);

        send4(30);
        check("near_zone", zone, 3);
        check("near_buz", buzzer, 1);
        send4(80);
        check("beep_zone", zone, 2);
        buz_hi = 0;
        buz_lo = 0;
        repeat (130) send(80, $urandom_range(20, 70));
        check("beep_on_seen", buz_hi, 1);
        check("beep_off_seen", buz_lo, 1);

        send4(2000);
        check("clamp_avg", avg_cm, 400);
        check("clamp_zone", zone, 1);
        send(0, 5);
        check("clamp_wrap", avg_cm, 300);

        send4(100);
        check("pre_stale_zone", zone, 2);
        for (int i = 0; i < 2000 && !stale; i++) @(negedge clk);
        check("stale_set", stale, 1);
        check("stale_zone", zone, 0);
        check("stale_buz", buzzer, 0);
        av_seen = 0;
        send(120, 5);
        check("stale_clr", stale, 0);
        send(120, 5);
        send(120, 5);
        check("rewarm_av", av_seen, 0);

        begin
            bit found = 0;
            for (int i = 0; i < 3000 && !found; i++) begin
                @(negedge clk);
                if (m_ms == TO - 1 && (m_ncyc % TD) == TD - 1) found = 1;
            end
            check("coinc_found", found, 1);
            dist_valid = 1;
            dist_cm = 11'd120;
            @(negedge clk);
            dist_valid = 0;
            check("coinc_stale", stale, 0);
            repeat (5) @(negedge clk);
            check("coinc_stale2", stale, 0);
        end

        repeat (300) begin
            int v, gap;
            v   = ($urandom_range(0, 19) == 0) ? 2047 : $urandom_range(0, 600);
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(950, 1300) : $urandom_range(1, 40);
            send(v, gap);
        end

        send4(100);
        check("prerst_zone", zone, 2);
        repeat (30) @(negedge clk);
        #3 rst = 1;
        #1;
        check("arst_avg", avg_cm, 0);
        check("arst_av", avg_valid, 0);
        check("arst_zone", zone, 0);
        check("arst_buz", buzzer, 0);
        check("arst_stale", stale, 0);
        @(negedge clk);
        rst = 0;
        av_seen = 0;
        repeat (3) send(100, 5);
        check("post_rst_av", av_seen, 0);
        check("post_rst_zone", zone, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
